// File: rtl/lreport_arbiter.sv
// Two-port packet arbiter merging beacon reports and transit traffic.
// Optional idle-timeout abort enabled by defining LREPORT_ARB_TIMEOUT_EN.
module lreport_arbiter #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_rpt_req,
  input  logic [133:0] in_rpt_data,
  input  logic         in_rpt_data_wr,
  input  logic         in_rpt_valid,
  input  logic         in_rpt_valid_wr,
  input  logic         in_fwd_req,
  input  logic [133:0] in_fwd_data,
  input  logic         in_fwd_data_wr,
  input  logic         in_fwd_valid,
  input  logic         in_fwd_valid_wr,
  input  logic         in_out_alf,
  output logic         out_rpt_grant,
  output logic         out_fwd_grant,
  output logic [133:0] out_data,
  output logic         out_data_wr,
  output logic         out_valid,
  output logic         out_valid_wr,
  output logic         out_busy,
  output logic [7:0]   out_drop_cnt,
  output logic [7:0]   out_timeout_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    TRAN   = 3'd2,
    WAIT_V = 3'd3,
    ABRT   = 3'd4
  } state_e;

  state_e       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic         own_q, own_d;
  logic         rgnt_q, rgnt_d;
  logic         fgnt_q, fgnt_d;
  logic [133:0] data_q, data_d;
  logic         dwr_q, dwr_d;
  logic         valid_q, valid_d;
  logic         vwr_q, vwr_d;
  logic         busy_q, busy_d;
  logic [7:0]   drop_q, drop_d;
  logic [7:0]   tmo_q, tmo_d;

`ifdef LREPORT_ARB_TIMEOUT_EN
  logic [15:0]  idle_q, idle_d;
`else
  logic         unused_tmo_cyc;
  assign unused_tmo_cyc = ^TIMEOUT_CYC;
`endif

  logic [133:0] g_data;
  logic         g_dwr;
  logic         g_valid;
  logic         g_vwr;
  logic         o_dwr;
  logic         o_vwr;
  logic         g_tail;
  logic [2:0]   n_drop;
  logic [8:0]   drop_sum;

  // own_q: 0 = report port, 1 = forward port
  always_comb begin
    if (own_q) begin
      g_data  = in_fwd_data;
      g_dwr   = in_fwd_data_wr;
      g_valid = in_fwd_valid;
      g_vwr   = in_fwd_valid_wr;
      o_dwr   = in_rpt_data_wr;
      o_vwr   = in_rpt_valid_wr;
    end else begin
      g_data  = in_rpt_data;
      g_dwr   = in_rpt_data_wr;
      g_valid = in_rpt_valid;
      g_vwr   = in_rpt_valid_wr;
      o_dwr   = in_fwd_data_wr;
      o_vwr   = in_fwd_valid_wr;
    end
    g_tail = (g_data[133:132] == 2'b10);
  end

  always_comb begin
    if (state_q == IDLE) begin
      n_drop = {2'b0, in_rpt_data_wr}
             + {2'b0, in_rpt_valid_wr}
             + {2'b0, in_fwd_data_wr}
             + {2'b0, in_fwd_valid_wr};
    end else begin
      n_drop = {2'b0, o_dwr} + {2'b0, o_vwr};
    end
    drop_sum = {1'b0, drop_q} + {6'b0, n_drop};
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    rgnt_d  = 1'b0;
    fgnt_d  = 1'b0;
    data_d  = '0;
    dwr_d   = 1'b0;
    valid_d = 1'b0;
    vwr_d   = 1'b0;
    tmo_d   = tmo_q;
    drop_d  = drop_sum[8] ? 8'hFF : drop_sum[7:0];
`ifdef LREPORT_ARB_TIMEOUT_EN
    idle_d  = idle_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (!in_out_alf && (in_rpt_req || in_fwd_req)) begin
          own_d   = (in_rpt_req && in_fwd_req) ? ptr_q : in_fwd_req;
          rgnt_d  = ~own_d;
          fgnt_d  = own_d;
          state_d = GRANT;
        end
      end
      GRANT, TRAN: begin
        state_d = TRAN;
        if (g_dwr) begin
          data_d = g_data;
          dwr_d  = 1'b1;
          if (g_tail) begin
            if (g_vwr) begin
              valid_d = g_valid;
              vwr_d   = 1'b1;
              state_d = IDLE;
              ptr_d   = ~ptr_q;
            end else begin
              state_d = WAIT_V;
            end
          end
        end
      end
      WAIT_V: begin
        if (g_vwr) begin
          valid_d = g_valid;
          vwr_d   = 1'b1;
          state_d = IDLE;
          ptr_d   = ~ptr_q;
        end
      end
      ABRT: begin
        vwr_d   = 1'b1;
        state_d = IDLE;
        ptr_d   = ~ptr_q;
        tmo_d   = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase

`ifdef LREPORT_ARB_TIMEOUT_EN
    // Idle counter runs only while a packet owns the bus
    if (state_q == GRANT || state_q == TRAN || state_q == WAIT_V) begin
      if (dwr_d || vwr_d) begin
        idle_d = '0;
      end else if (idle_q + 16'd1 >= TIMEOUT_CYC) begin
        idle_d = '0;
        if (state_q == WAIT_V) begin
          valid_d = 1'b0;
          vwr_d   = 1'b1;
          state_d = IDLE;
          ptr_d   = ~ptr_q;
          tmo_d   = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
        end else begin
          data_d  = {2'b10, 132'b0};
          dwr_d   = 1'b1;
          state_d = ABRT;
        end
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end else begin
      idle_d = '0;
    end
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      own_q   <= 1'b0;
      rgnt_q  <= 1'b0;
      fgnt_q  <= 1'b0;
      data_q  <= '0;
      dwr_q   <= 1'b0;
      valid_q <= 1'b0;
      vwr_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
      tmo_q   <= '0;
`ifdef LREPORT_ARB_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      rgnt_q  <= rgnt_d;
      fgnt_q  <= fgnt_d;
      data_q  <= data_d;
      dwr_q   <= dwr_d;
      valid_q <= valid_d;
      vwr_q   <= vwr_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      tmo_q   <= tmo_d;
`ifdef LREPORT_ARB_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign out_rpt_grant   = rgnt_q;
  assign out_fwd_grant   = fgnt_q;
  assign out_data        = data_q;
  assign out_data_wr     = dwr_q;
  assign out_valid       = valid_q;
  assign out_valid_wr    = vwr_q;
  assign out_busy        = busy_q;
  assign out_drop_cnt    = drop_q;
  assign out_timeout_cnt = tmo_q;

endmodule

// File: doc/lreport_arbiter.md
LREPORT_ARBITER -- requirements
Module: lreport_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'd512, max idle cycles for a granted requester before abort.
REQ-002 clk  input  1  clock; all logic on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_rpt_req  input  1  port 0 (beacon report generator): one complete packet is ready to send.
REQ-005 in_rpt_data  input  134  port 0 word: [133:132] 01=head, 11=middle, 10=tail; [127:0] payload.
REQ-006 in_rpt_data_wr  input  1  port 0 word strobe.
REQ-007 in_rpt_valid / in_rpt_valid_wr  input  1 / 1  port 0 end-of-packet status (1=good) and its strobe.
REQ-008 in_fwd_req, in_fwd_data[133:0], in_fwd_data_wr, in_fwd_valid, in_fwd_valid_wr  input  port 1 (transit traffic), same meanings as REQ-004..007.
REQ-009 in_out_alf  input  1  downstream almost-full.
REQ-010 out_rpt_grant / out_fwd_grant  output  1 / 1  one-cycle grant pulse to port 0 / port 1.
REQ-011 out_data, out_data_wr, out_valid, out_valid_wr  output  134/1/1/1  merged bus toward the switch.
REQ-012 out_busy  output  1  high whenever state is not IDLE.
REQ-013 out_drop_cnt  output  8  saturating count of words received on a non-granted port.
REQ-014 out_timeout_cnt  output  8  saturating count of timeout aborts.

Function
REQ-015 States: IDLE, GRANT, TRAN, WAIT_V; all outputs are registered.
REQ-016 IDLE: when in_out_alf=0 and any req=1, select winner, pulse its grant for 1 cycle, go to GRANT; when in_out_alf=1, no grant is issued.
REQ-017 Simultaneous requests: round-robin pointer selects the winner; pointer resets to port 0 and moves to the other port after each completed or aborted packet.
REQ-018 GRANT/TRAN: each granted-port word with data_wr=1 appears on out_data/out_data_wr exactly 1 cycle later, unmodified; GRANT transitions to TRAN on the next cycle.
REQ-019 Granted-port word with [133:132]=10 (tail) -> WAIT_V; if valid_wr arrives in the same cycle, it is forwarded and state returns to IDLE directly.
REQ-020 WAIT_V: granted-port valid/valid_wr are forwarded with 1-cycle latency, then state -> IDLE.
REQ-021 Words or valid_wr from the non-granted port, or from any port while in IDLE, are not forwarded and increment out_drop_cnt (saturates at 8'hFF).
REQ-022 out_data is 134'b0 and out_data_wr/out_valid_wr are 0 on every cycle nothing is forwarded.
REQ-023 in_out_alf does not interrupt a packet already granted.
REQ-024 Minimum gap: a new grant is issued no earlier than the first IDLE cycle after the previous packet's valid_wr was forwarded.

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, pointer=port 0, all outputs and counters=0.
REQ-026 Reset during a packet discards it; no tail or valid_wr is emitted afterwards for that packet.

Configuration
REQ-027 Macro LREPORT_ARB_TIMEOUT_EN defined: a 16-bit idle counter clears on grant and on every forwarded word or valid_wr, and increments otherwise in GRANT/TRAN/WAIT_V.
REQ-028 With the macro, when the counter reaches TIMEOUT_CYC: in GRANT/TRAN emit one word {2'b10,132'b0} with out_data_wr=1, then one cycle later out_valid=0, out_valid_wr=1; in WAIT_V emit only out_valid=0, out_valid_wr=1; then increment out_timeout_cnt, advance the pointer and go to IDLE.
REQ-029 Without the macro, the block waits indefinitely in each state, and out_timeout_cnt is constant 0.

Verification
REQ-030 Single port-0 request with a 4-word packet (01,11,11,10) and valid=1 -> out_rpt_grant pulse, 4 words out, each 1 cycle after its input, then out_valid=1, out_valid_wr=1.
REQ-031 Both req=1 from reset, each sending 2-word packets -> grant order port0, port1, port0; no interleaving on out_data.
REQ-032 in_out_alf=1 with in_fwd_req=1 for 20 cycles -> no grant; alf drops to 0 -> grant on the following cycle.
REQ-033 Port 1 drives 3 words while port 0 is granted -> out_drop_cnt=3 and port-0 output is unchanged.
REQ-034 With LREPORT_ARB_TIMEOUT_EN and TIMEOUT_CYC=8: head only, then silence -> forced tail word after 8 idle cycles, out_valid=0 strobe, out_timeout_cnt=1, out_busy=0.
REQ-035 rst_n pulsed mid-packet -> all outputs 0 immediately, no tail emitted, next grant goes to port 0.
